// File: rtl/cmd_write_arbiter.sv
// Single-writer arbiter for the command register bank: merges buffered SPI writes
// with handshaked local controller writes, one register write per SYS_CLK cycle.
module cmd_write_arbiter #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 16,
  parameter int MAX_SPI_BURST = 4,
  parameter int WR_LO         = 25,
  parameter int WR_HI         = 40
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              spi_wr_valid,
  input  logic [ADDR_W-1:0] spi_wr_addr,
  input  logic [DATA_W-1:0] spi_wr_data,
  input  logic              loc_req,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_data,
  output logic              loc_gnt,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_src,
  output logic              spi_overflow,
  input  logic              ovf_clr,
  output logic [7:0]        drop_cnt
);

  localparam int                  STREAK_W   = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_SPI_BURST);

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_W'(WR_LO)) && (a <= ADDR_W'(WR_HI));
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [ADDR_W-1:0]   fifo_addr [2];
  logic [DATA_W-1:0]   fifo_data [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          fifo_cnt;
  logic                fifo_ne;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                ovf_evt;
  logic [STREAK_W-1:0] streak;

  logic                pick_loc_p0;
  logic                pick_spi_p0;
  logic                vld_p0;
  logic                src_p0;
  logic                keep_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   data_p0;

  logic                vld_p1;
  logic                src_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                ovf_q;
  logic [7:0]          drop_q;

  assign fifo_ne   = (fifo_cnt != 2'd0);
  assign fifo_full = (fifo_cnt == 2'd2);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push      = spi_wr_valid && (!fifo_full || pop);
  assign ovf_evt   = spi_wr_valid && fifo_full && !pop;

  // Stage p0: arbitration on registered FIFO head, streak and live loc_req
  always_comb begin
    pick_loc_p0 = 1'b0;
    pick_spi_p0 = 1'b0;
    if (!SYS_RST) begin
      if (loc_req && (!fifo_ne || (streak == STREAK_MAX))) begin
        pick_loc_p0 = 1'b1;
      end else if (fifo_ne) begin
        pick_spi_p0 = 1'b1;
      end
    end
    vld_p0  = pick_loc_p0 || pick_spi_p0;
    src_p0  = pick_loc_p0;
    addr_p0 = pick_loc_p0 ? loc_addr : fifo_addr[rd_ptr];
    data_p0 = pick_loc_p0 ? loc_data : fifo_data[rd_ptr];
    keep_p0 = vld_p0 && addr_in_range(addr_p0);
  end

  assign pop     = pick_spi_p0;
  assign loc_gnt = pick_loc_p0;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + 2'd1;
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= spi_wr_addr;
      fifo_data[wr_ptr] <= spi_wr_data;
    end
  end

  // Streak only grows while the local requester is actually being held off.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      streak <= '0;
    end else if (pick_spi_p0 && loc_req) begin
      streak <= streak + 1'b1;
    end else begin
      streak <= '0;
    end
  end

  // Stage p1: registered write port toward the register bank
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      vld_p1  <= 1'b0;
      src_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= keep_p0;
      if (vld_p0) begin
        src_p1  <= src_p0;
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      ovf_q  <= 1'b0;
      drop_q <= 8'd0;
    end else begin
      if (ovf_evt) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
      if (vld_p0 && !keep_p0) drop_q <= sat_inc8(drop_q);
    end
  end

  assign reg_we       = vld_p1;
  assign reg_src      = src_p1;
  assign reg_addr     = addr_p1;
  assign reg_wdata    = data_p1;
  assign spi_overflow = ovf_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_cmd_write_arbiter.sv
// Directed bench for cmd_write_arbiter: queue-based reference model checked every
// cycle, plus literal expectations on latency, ordering, overflow and drop count.
module tb_cmd_write_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int MAXB   = 4;

  logic              SYS_CLK;
  logic              SYS_RST;
  logic              spi_wr_valid;
  logic [ADDR_W-1:0] spi_wr_addr;
  logic [DATA_W-1:0] spi_wr_data;
  logic              loc_req;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_data;
  logic              loc_gnt;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_src;
  logic              spi_overflow;
  logic              ovf_clr;
  logic [7:0]        drop_cnt;

  cmd_write_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_SPI_BURST(MAXB), .WR_LO(25), .WR_HI(40)
  ) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST),
    .spi_wr_valid(spi_wr_valid), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
    .loc_req(loc_req), .loc_addr(loc_addr), .loc_data(loc_data), .loc_gnt(loc_gnt),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_src(reg_src),
    .spi_overflow(spi_overflow), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: pending SPI writes as a queue, outputs as plain variables.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              m_q[$];
  int                m_streak = 0;
  bit                m_we = 0, m_src = 0, m_ovf = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_drop = 0;

  function automatic bit writable(input logic [ADDR_W-1:0] a);
    return (a >= 25) && (a <= 40);
  endfunction

  always @(posedge SYS_CLK) begin
    ent_t w;
    bit   take_loc, take_spi;
    cyc++;
    if (SYS_RST) begin
      m_q.delete();
      m_streak = 0;
      m_we = 0; m_src = 0; m_ovf = 0; m_addr = '0; m_data = '0; m_drop = 0;
      chk_en = 1'b1;
    end else begin
      take_loc = loc_req && (m_q.size() == 0 || m_streak == MAXB);
      take_spi = !take_loc && (m_q.size() > 0);
      m_we = 0;
      if (take_loc || take_spi) begin
        if (take_loc) begin
          w.a = loc_addr; w.d = loc_data;
        end else begin
          w = m_q.pop_front();
        end
        m_src  = take_loc;
        m_addr = w.a;
        m_data = w.d;
        if (writable(w.a)) m_we = 1;
        else if (m_drop < 255) m_drop++;
      end
      m_streak = (take_spi && loc_req) ? m_streak + 1 : 0;
      if (spi_wr_valid) begin
        if (m_q.size() < 2) m_q.push_back({spi_wr_addr, spi_wr_data});
        else m_ovf = 1;
      end else if (ovf_clr) begin
        m_ovf = 0;
      end
    end
  end

  // Per-cycle comparison and write log, sampled on the falling edge.
  bit                wlog[$];
  int                we_cnt = 0, gnt_cnt = 0, t_we = -1;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  bit                last_src;

  always @(negedge SYS_CLK) begin
    bit exp_gnt;
    if (chk_en) begin
      exp_gnt = !SYS_RST && loc_req && (m_q.size() == 0 || m_streak == MAXB);
      check("loc_gnt", 32'(loc_gnt), 32'(exp_gnt));
      check("reg_we", 32'(reg_we), 32'(m_we));
      if (m_we) begin
        check("reg_addr", 32'(reg_addr), 32'(m_addr));
        check("reg_wdata", 32'(reg_wdata), 32'(m_data));
        check("reg_src", 32'(reg_src), 32'(m_src));
      end
      check("spi_overflow", 32'(spi_overflow), 32'(m_ovf));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (reg_we === 1'b1) begin
        wlog.push_back(reg_src);
        last_addr = reg_addr;
        last_data = reg_wdata;
        last_src  = reg_src;
        t_we      = cyc;
        we_cnt++;
      end
      if (loc_gnt === 1'b1) gnt_cnt++;
    end
  end

  task automatic step();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic wait_gnt(output int t, output bit ok);
    ok = 0;
    t  = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge SYS_CLK);
      if (loc_gnt === 1'b1) begin
        t  = cyc;
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t_push, t_req, t_gnt, we0, gnt0, ones, first_loc;
    bit ok, gs;
    SYS_RST = 1; spi_wr_valid = 0; spi_wr_addr = '0; spi_wr_data = '0;
    loc_req = 0; loc_addr = '0; loc_data = '0; ovf_clr = 0;
    step(); step();
    SYS_RST = 0;
    check("rst_we", 32'(reg_we), 0);
    check("rst_ovf", 32'(spi_overflow), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_addr", 32'(reg_addr), 0);

    // Single SPI write: reg_we two cycles after the strobe
    step();
    we0 = we_cnt;
    spi_wr_valid = 1; spi_wr_addr = 10'd33; spi_wr_data = 16'h1234; t_push = cyc;
    step();
    spi_wr_valid = 0;
    repeat (4) step();
    check("spi_we_count", 32'(we_cnt - we0), 1);
    check("spi_latency", 32'(t_we - t_push), 2);
    check("spi_addr", 32'(last_addr), 33);
    check("spi_data", 32'(last_data), 32'h1234);
    check("spi_src", 32'(last_src), 0);

    // Local only: grant in the request cycle, write the next cycle
    we0 = we_cnt;
    loc_req = 1; loc_addr = 10'd25; loc_data = 16'h0800; t_req = cyc;
    wait_gnt(t_gnt, ok);
    step();
    loc_req = 0;
    repeat (3) step();
    check("loc_gnt_seen", 32'(ok), 1);
    check("loc_gnt_cycle", 32'(t_gnt - t_req), 0);
    check("loc_latency", 32'(t_we - t_gnt), 1);
    check("loc_we_count", 32'(we_cnt - we0), 1);
    check("loc_src", 32'(last_src), 1);
    check("loc_addr", 32'(last_addr), 25);
    check("loc_data", 32'(last_data), 32'h0800);

    // Starvation bound: order SPI x4, LOC, then remaining SPI
    wlog.delete();
    gs = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      spi_wr_valid = 1; spi_wr_addr = 10'(25 + i); spi_wr_data = 16'(16'h0100 + i);
      loc_req = (i >= 1) && !gs; loc_addr = 10'd30; loc_data = 16'hABCD;
      @(negedge SYS_CLK);
      if (loc_gnt === 1'b1) gs = 1;
    end
    step();
    spi_wr_valid = 0; loc_req = 0;
    repeat (5) step();
    ones = 0; first_loc = -1;
    foreach (wlog[k]) begin
      if (wlog[k]) begin
        ones++;
        if (first_loc < 0) first_loc = k;
      end
    end
    check("starve_writes", 32'(wlog.size()), 13);
    check("starve_loc_count", 32'(ones), 1);
    check("starve_loc_slot", 32'(first_loc), 4);

    // Overflow: full FIFO on a local-grant cycle, with ovf_clr colliding (set wins)
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      spi_wr_valid = 1; spi_wr_addr = 10'(25 + i); spi_wr_data = 16'(16'h0200 + i);
      loc_req = (i >= 1); loc_addr = 10'd31; loc_data = 16'h5555;
      ovf_clr = (i == 10);
      if (i == 10) check("ovf_full_with_pop", 32'(spi_overflow), 0);
    end
    step();
    spi_wr_valid = 0; loc_req = 0; ovf_clr = 0;
    check("ovf_set_wins", 32'(spi_overflow), 1);
    step();
    ovf_clr = 1;
    step();
    ovf_clr = 0;
    check("ovf_cleared", 32'(spi_overflow), 0);
    repeat (4) step();

    // Address filter: both slots consumed, nothing written
    we0 = we_cnt;
    spi_wr_valid = 1; spi_wr_addr = 10'd5; spi_wr_data = 16'hDEAD;
    step();
    spi_wr_valid = 0;
    loc_req = 1; loc_addr = 10'd41; loc_data = 16'h1111;
    wait_gnt(t_gnt, ok);
    step();
    loc_req = 0;
    repeat (3) step();
    check("filt_gnt_seen", 32'(ok), 1);
    check("filt_no_we", 32'(we_cnt - we0), 0);
    check("filt_drop2", 32'(drop_cnt), 2);

    for (int i = 0; i < 300; i++) begin
      spi_wr_valid = 1; spi_wr_addr = (i % 2) ? 10'd0 : 10'd1023; spi_wr_data = 16'(i);
      step();
    end
    spi_wr_valid = 0;
    repeat (3) step();
    check("drop_saturate", 32'(drop_cnt), 255);

    // Reset mid-operation with queued SPI writes and a pending local request
    spi_wr_valid = 1; spi_wr_addr = 10'd26; spi_wr_data = 16'h0026;
    step();
    we0 = we_cnt; gnt0 = gnt_cnt;
    spi_wr_addr = 10'd27; spi_wr_data = 16'h0027;
    SYS_RST = 1; loc_req = 1; loc_addr = 10'd28; loc_data = 16'h0028;
    step();
    SYS_RST = 0; loc_req = 0; spi_wr_valid = 0;
    repeat (5) step();
    check("rst_mid_no_we", 32'(we_cnt - we0), 0);
    check("rst_mid_no_gnt", 32'(gnt_cnt - gnt0), 0);
    check("rst_mid_ovf", 32'(spi_overflow), 0);
    check("rst_mid_drop", 32'(drop_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
